// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath blocks.
// Holds the sequential divider's state encoding and default widths.
package mips_pkg;

    localparam int DIV_WIDTH     = 32;
    localparam int DIV_CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,q} left and subtract the divisor
// when it fits. Purely combinational.
module div_step
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // With rem < divisor the shifted value stays below 2*divisor, so one extra
    // bit is enough for the trial sign; with divisor 0 rem only ever holds a prefix of |a|.
    assign w_shift = {rem, q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, divisor};

    always_comb begin
        rem_next = w_shift[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            rem_next = w_trial[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mips_seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU feeding the LO/HI register block.
// Fixed 33-cycle latency from an accepted start to the done pulse.
module mips_seq_divider
    import mips_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_neg_q;
    logic             w_neg_r;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_abs_a = (is_signed && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
    assign w_abs_b = (is_signed && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;
    assign w_neg_q = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]) & (|operand_b);
    assign w_neg_r = is_signed & operand_a[WIDTH-1];

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .q        (r_q),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .q_next   (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        r_state <= DIV_BUSY;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_q     <= w_abs_a;
                        r_div   <= w_abs_b;
                        r_neg_q <= w_neg_q;
                        r_neg_r <= w_neg_r;
                    end else begin
                        r_state <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    // Final step: results are sign-corrected straight from the step outputs.
                    if (r_cnt == LAST_CNT) begin
                        r_state <= DIV_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_lo    <= r_neg_q ? (~w_q_next + 1'b1) : w_q_next;
                        r_hi    <= r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign out_lo = r_lo;
    assign out_hi = r_hi;

endmodule

// File: tb/tb_mips_seq_divider.sv
// Randomized self-checking bench for mips_seq_divider against an arithmetic model.
module tb_mips_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] out_lo;
    logic [31:0] out_hi;

    int checks;
    int failures;

    logic [31:0] prev_lo;
    logic [31:0] prev_hi;

    mips_seq_divider #(
        .WIDTH     (32),
        .CNT_W     (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .out_lo    (out_lo),
        .out_hi    (out_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the architectural rules for b == 0.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            lo = sq[31:0];
            hi = sr[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Issues one divide (start sampled at the next rising edge) and checks timing and results.
    // ignore_at > 0 pulses start with junk operands during that BUSY cycle.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int ignore_at);
        logic [31:0] exp_lo, exp_hi;
        int k, busy_n;
        bit got_done, both, stable_ok;
        model(s, a, b, exp_lo, exp_hi);
        @(negedge clk);
        start = 1'b1;
        is_signed = s;
        operand_a = a;
        operand_b = b;
        k = 0; busy_n = 0; got_done = 0; both = 0; stable_ok = 1;
        while (!got_done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            start = (k == ignore_at);
            operand_a = $urandom;
            operand_b = $urandom;
            is_signed = 1'($urandom);
            if (busy && done) both = 1;
            if (busy) busy_n++;
            if (done) got_done = 1;
            else if (out_lo !== prev_lo || out_hi !== prev_hi) stable_ok = 0;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(k), 32'd33);
        check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
        check_eq({tag, "_busy_and_done"}, 32'(both), 32'd0);
        check_eq({tag, "_held"}, 32'(stable_ok), 32'd1);
        check_eq({tag, "_lo"}, out_lo, exp_lo);
        check_eq({tag, "_hi"}, out_hi, exp_hi);
        prev_lo = exp_lo;
        prev_hi = exp_hi;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          dn_seen;
        checks = 0; failures = 0;
        prev_lo = '0; prev_hi = '0;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0;
        operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_lo", out_lo, 32'd0);
        check_eq("reset_hi", out_hi, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0);
        idle_cycles(2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_div("div_7_m2_b2b", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        idle_cycles(1);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 0);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
        idle_cycles(3);
        do_div("ignore_start", 1'b0, 32'd1000, 32'd33, 10);
        idle_cycles(2);

        // Reset in the middle of a divide: outputs clear and no done follows.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; operand_a = 32'd999; operand_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_lo", out_lo, 32'd0);
        check_eq("midrst_hi", out_hi, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dn_seen++;
        end
        check_eq("midrst_no_activity", 32'(dn_seen), 32'd0);
        prev_lo = '0; prev_hi = '0;

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = ~32'($urandom_range(0, 15));
                3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            do_div($sformatf("rand%0d", i), rs, ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 31)) : 0);
            if (i % 2 == 0) idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
